dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder end of the CPU data-memory request interface: accepts one load/store per handshake,
//  inserts WAIT_STATES, returns read data, and owns the memory-side LL/SC reservation.
//  Sits behind the CPU MEM stage; replaces the zero-wait data memory plus CPU-side link register.
// PARAMETERS
//  BITS         32   data/address width
//  WORDS        256  number of memory words
//  BASE_ADDR    0    first word address; addressing is word-granular
//  WAIT_STATES  1    extra cycles between accept and response (0..15)
// PORTS
//  clk         in   1     system clock
//  rst_        in   1     asynchronous active-low reset
//  req_valid   in   1     request present
//  req_ready   out  1     responder idle, request accepted when req_valid & req_ready
//  addr        in   BITS  word address
//  rw_         in   1     1 = read, 0 = write
//  wdata       in   BITS  write data
//  byte_en     in   4     active-low lane enables, 4'b0000 = full word
//  load_link_  in   1     0 = load-linked read
//  check_link  in   1     1 = store-conditional
//  rsp_valid   out  1     one-cycle response strobe
//  rdata       out  BITS  read data, valid with rsp_valid
//  sc_ok       out  1     SC succeeded, valid with rsp_valid
//  addr_err    out  1     address outside [BASE_ADDR, BASE_ADDR+WORDS-1], valid with rsp_valid
// BEHAVIOUR
//  - Reset values: state IDLE, req_ready 1, rsp_valid 0, rdata 0, sc_ok 0, addr_err 0, link_valid 0.
//    Memory array is not reset.
//  - FSM:
//    IDLE -accept-> WAIT when WAIT_STATES > 0, else directly to RESP.
//    WAIT counts WAIT_STATES cycles, then -> RESP.
//    RESP lasts one cycle with rsp_valid = 1, then -> IDLE.
//  - req_ready = 1 only in IDLE. addr, rw_, wdata, byte_en, load_link_ and check_link are
//    registered at accept; later input changes are ignored.
//  - Latency: rsp_valid asserts exactly WAIT_STATES+1 cycles after the accept edge.
//    The next accept is possible the cycle after RESP.
//    Responses have no backpressure.
//  - Index = addr - BASE_ADDR, BITS-wide unsigned. Out of range:
//    addr_err = 1, no write, rdata = 0, sc_ok = 0, reservation unchanged.
//  - Write commit happens on the edge entering RESP. Only lanes with byte_en[i] = 0 are written.
//  - Read: rdata = full word, registered into RESP. byte_en is ignored on reads.
//  - LL (load_link_ = 0, rw_ = 1): performs a normal read; sets link_addr = addr and link_valid = 1.
//  - SC (check_link = 1; rw_ is ignored and the op is treated as a write):
//    if link_valid and link_addr == addr, perform the write and set sc_ok = 1;
//    otherwise no write and sc_ok = 0.
//    link_valid clears in both cases.
//  - check_link = 1 together with load_link_ = 0: SC wins, load_link_ is ignored.
//  - A plain write with link_valid and addr == link_addr clears link_valid.
//  - sc_ok = 0 for every non-SC response.
//  - rsp_valid is high only in RESP. rdata, sc_ok and addr_err hold their last values outside RESP.
//  - Reset mid-operation (WAIT or RESP): return to IDLE, drop the pending op
//    (a write not yet committed is lost), clear link_valid.
// STRUCTURE
//  - Package dmem_pkg: typedef enum {IDLE, WAIT, RESP} dmem_state_t; LANES = 4;
//    WAIT_CNT_BITS = 4.
//  - Sub-module link_monitor: holds link_addr/link_valid.
//    Inputs: set, check, plain-write, addr. Output: match.
//  - Memory array and FSM stay inline.
// TESTING
//  1. WAIT_STATES=2: write 32'hDEAD_BEEF @5, then read @5
//     -> rsp_valid exactly 3 cycles after each accept, rdata = DEADBEEF.
//  2. Word @7 = 32'h1122_3344; write 32'hAABB_CCDD @7 with byte_en = 4'b1100
//     -> read returns 32'h1122_CCDD.
//  3. LL @9, then SC @9 with wdata = 5 -> sc_ok = 1, read @9 = 5.
//     A second SC @9 -> sc_ok = 0, word still 5.
//  4. LL @9, plain write @9 = 1, SC @9 = 2 -> sc_ok = 0, word = 1.
//     LL @9 then SC @10 -> sc_ok = 0, word @10 unchanged.
//  5. Read @WORDS -> addr_err = 1, rdata = 0.
//     Write @WORDS+3 -> addr_err = 1, array unchanged.
//  6. Assert rst_ = 0 during WAIT of a write @3 -> rsp_valid stays 0, req_ready = 1 next cycle,
//     word @3 unchanged, subsequent SC fails.
//     WAIT_STATES=0: back-to-back reads -> accept every 2nd cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int LANES         = 4;
    localparam int WAIT_CNT_BITS = 4;

endpackage
`default_nettype wire

// File: rtl/dmem_link_monitor.sv
`default_nettype none
// ============================================================================
// Module      : link_monitor
// Description : LL/SC reservation register; match reports a live link on addr.
// Revision    : 1.0 - initial release
// ============================================================================
module link_monitor #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            set,
    input  logic            check,
    input  logic            plain_write,
    input  logic [BITS-1:0] addr,
    output logic            match
);

    logic            r_link_valid;
    logic [BITS-1:0] r_link_addr;

    // set/check/plain_write are single-cycle commit strobes and never overlap
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_link_valid <= 1'b0;
            r_link_addr  <= '0;
        end else if (set) begin
            r_link_valid <= 1'b1;
            r_link_addr  <= addr;
        end else if (check || (plain_write && match)) begin
            r_link_valid <= 1'b0;
        end
    end

    assign match = r_link_valid && (r_link_addr == addr);

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Wait-stated data-memory responder with memory-side LL/SC link.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          BITS        = 32,
    parameter int          WORDS       = 256,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int          WAIT_STATES = 1
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [BITS-1:0]  addr,
    input  logic             rw_,
    input  logic [BITS-1:0]  wdata,
    input  logic [LANES-1:0] byte_en,
    input  logic             load_link_,
    input  logic             check_link,
    output logic             rsp_valid,
    output logic [BITS-1:0]  rdata,
    output logic             sc_ok,
    output logic             addr_err
);

    localparam int                       c_IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int                       c_LANE_W    = BITS / LANES;
    localparam logic [BITS-1:0]          c_BASE      = BITS'(BASE_ADDR);
    localparam logic [BITS-1:0]          c_WORDS     = BITS'(WORDS);
    localparam logic [WAIT_CNT_BITS-1:0] c_WAIT_LAST = WAIT_CNT_BITS'(WAIT_STATES - 1);

    dmem_state_t              r_state, w_next;
    logic [WAIT_CNT_BITS-1:0] r_cnt;
    logic [BITS-1:0]          r_addr, r_wdata, r_rdata;
    logic [LANES-1:0]         r_be;
    logic                     r_rw_, r_ll_, r_sc, r_sc_ok, r_addr_err;
    logic [BITS-1:0]          r_mem [WORDS];

    logic [BITS-1:0]          w_op_addr, w_op_wdata, w_index;
    logic [LANES-1:0]         w_op_be;
    logic                     w_op_rw_, w_op_ll_, w_op_sc;
    logic [c_IDX_W-1:0]       w_idx;
    logic                     w_accept, w_enter_resp, w_in_range, w_match;
    logic                     w_is_read, w_is_plain_wr, w_do_write;

    // With zero wait states the op commits on its own accept edge, so read it from the ports
    assign w_op_addr  = (r_state == IDLE) ? addr       : r_addr;
    assign w_op_wdata = (r_state == IDLE) ? wdata      : r_wdata;
    assign w_op_be    = (r_state == IDLE) ? byte_en    : r_be;
    assign w_op_rw_   = (r_state == IDLE) ? rw_        : r_rw_;
    assign w_op_ll_   = (r_state == IDLE) ? load_link_ : r_ll_;
    assign w_op_sc    = (r_state == IDLE) ? check_link : r_sc;

    assign w_accept      = req_valid && (r_state == IDLE);
    assign w_enter_resp  = (w_next == RESP) && (r_state != RESP);
    assign w_index       = w_op_addr - c_BASE;
    assign w_idx         = w_index[c_IDX_W-1:0];
    assign w_in_range    = w_index < c_WORDS;
    assign w_is_read     = !w_op_sc && w_op_rw_;
    assign w_is_plain_wr = !w_op_sc && !w_op_rw_;
    assign w_do_write    = w_enter_resp && w_in_range &&
                           (w_is_plain_wr || (w_op_sc && w_match));

    link_monitor #(
        .BITS        (BITS)
    ) u_link (
        .clk         (clk),
        .rst_        (rst_),
        .set         (w_enter_resp && w_in_range && w_is_read && !w_op_ll_),
        .check       (w_enter_resp && w_in_range && w_op_sc),
        .plain_write (w_enter_resp && w_in_range && w_is_plain_wr),
        .addr        (w_op_addr),
        .match       (w_match)
    );

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = (WAIT_STATES == 0) ? RESP : WAIT;
            end
            WAIT: if (r_cnt == c_WAIT_LAST) w_next = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_rw_      <= 1'b1;
            r_ll_      <= 1'b1;
            r_sc       <= 1'b0;
            r_rdata    <= '0;
            r_sc_ok    <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_addr  <= addr;
                r_wdata <= wdata;
                r_be    <= byte_en;
                r_rw_   <= rw_;
                r_ll_   <= load_link_;
                r_sc    <= check_link;
            end
            if (w_enter_resp) begin
                r_rdata    <= (w_in_range && w_is_read) ? r_mem[w_idx] : '0;
                r_sc_ok    <= w_in_range && w_op_sc && w_match;
                r_addr_err <= !w_in_range;
            end
        end
    end

    // Array is deliberately not reset; lanes with an active-low enable are written
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int i = 0; i < LANES; i++) begin
                if (!w_op_be[i]) r_mem[w_idx][i*c_LANE_W +: c_LANE_W] <= w_op_wdata[i*c_LANE_W +: c_LANE_W];
            end
        end
    end

    assign rdata    = r_rdata;
    assign sc_ok    = r_sc_ok;
    assign addr_err = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench: two responders (2 and 0 wait states).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        sc_ok;
        logic        err;
        logic        chk_rd;
        int          lat;
        longint      acc;
    } rsp_t;

    logic        clk;
    logic        rst_;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [31:0] addr       [2];
    logic        rw_        [2];
    logic [31:0] wdata      [2];
    logic [3:0]  byte_en    [2];
    logic        load_link_ [2];
    logic        check_link [2];
    logic        rsp_valid  [2];
    logic [31:0] rdata      [2];
    logic        sc_ok      [2];
    logic        addr_err   [2];

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;

    // reference model state
    int          ws    [2] = '{2, 0};
    int          base  [2] = '{0, 16};
    int          words [2] = '{256, 64};
    logic [31:0] mem   [2][256];
    logic        lv    [2] = '{1'b0, 1'b0};
    logic [31:0] la    [2] = '{32'h0, 32'h0};

    dmem_responder #(.BITS(32), .WORDS(256), .BASE_ADDR(0), .WAIT_STATES(2)) u_dut0 (
        .clk(clk), .rst_(rst_), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .addr(addr[0]), .rw_(rw_[0]), .wdata(wdata[0]), .byte_en(byte_en[0]),
        .load_link_(load_link_[0]), .check_link(check_link[0]), .rsp_valid(rsp_valid[0]),
        .rdata(rdata[0]), .sc_ok(sc_ok[0]), .addr_err(addr_err[0])
    );

    dmem_responder #(.BITS(32), .WORDS(64), .BASE_ADDR(16), .WAIT_STATES(0)) u_dut1 (
        .clk(clk), .rst_(rst_), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .addr(addr[1]), .rw_(rw_[1]), .wdata(wdata[1]), .byte_en(byte_en[1]),
        .load_link_(load_link_[1]), .check_link(check_link[1]), .rsp_valid(rsp_valid[1]),
        .rdata(rdata[1]), .sc_ok(sc_ok[1]), .addr_err(addr_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string fmt(input rsp_t r);
        return $sformatf("lat=%0d rdata=%h sc_ok=%b err=%b", r.lat, r.rdata, r.sc_ok, r.err);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (!be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // Behavioural model of one transaction: address check, LL/SC rules, lane-merged write
    task automatic model_op(input int d, input logic [31:0] a, input logic rw, input logic [31:0] wd,
                            input logic [3:0] be, input logic ll, input logic sc, output rsp_t e);
        logic [31:0] idx;
        logic        ok;
        e = '{rdata: 32'h0, sc_ok: 1'b0, err: 1'b0, chk_rd: 1'b0, lat: ws[d] + 1, acc: 0};
        idx = a - 32'(base[d]);
        if (idx >= 32'(words[d])) begin
            e.err    = 1'b1;
            e.chk_rd = 1'b1;
            return;
        end
        if (sc) begin
            ok      = lv[d] && (la[d] == a);
            lv[d]   = 1'b0;
            e.sc_ok = ok;
            if (ok) mem[d][idx] = merge(mem[d][idx], wd, be);
        end else if (!rw) begin
            if (lv[d] && (la[d] == a)) lv[d] = 1'b0;
            mem[d][idx] = merge(mem[d][idx], wd, be);
        end else begin
            e.rdata  = mem[d][idx];
            e.chk_rd = 1'b1;
            if (!ll) begin
                lv[d] = 1'b1;
                la[d] = a;
            end
        end
    endtask

    task automatic issue(input int d, input logic [31:0] a, input logic rw, input logic [31:0] wd,
                         input logic [3:0] be, input logic ll, input logic sc, output rsp_t g);
        int n;
        g = '{rdata: 32'h0, sc_ok: 1'b0, err: 1'b0, chk_rd: 1'b0, lat: 0, acc: 0};
        @(negedge clk);
        req_valid[d] = 1'b1; addr[d] = a; rw_[d] = rw; wdata[d] = wd;
        byte_en[d] = be; load_link_[d] = ll; check_link[d] = sc;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        g.acc = cyc;
        @(negedge clk);
        // scramble the request lines: the responder must use what it captured
        req_valid[d] = 1'b0; addr[d] = $urandom; rw_[d] = 1'($urandom); wdata[d] = $urandom;
        byte_en[d] = 4'($urandom); load_link_[d] = 1'($urandom); check_link[d] = 1'($urandom);
        for (int k = 1; k <= 40; k++) begin
            if (rsp_valid[d]) begin
                g.lat = k; g.rdata = rdata[d]; g.sc_ok = sc_ok[d]; g.err = addr_err[d];
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic op(input int d, input logic [31:0] a, input logic rw, input logic [31:0] wd,
                      input logic [3:0] be, input logic ll, input logic sc, output rsp_t g, output rsp_t e);
        issue(d, a, rw, wd, be, ll, sc, g);
        model_op(d, a, rw, wd, be, ll, sc, e);
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rdata[d] !== 32'h0 ||
                sc_ok[d] !== 1'b0 || addr_err[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_state[%0d]: ready=%b rsp_valid=%b rdata=%h sc_ok=%b err=%b, want 1 0 0 0 0",
                         d, req_ready[d], rsp_valid[d], rdata[d], sc_ok[d], addr_err[d]);
            end
        end
    endtask

    task automatic test_init();
        rsp_t g, e;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < words[d]; i++)
                op(d, 32'(base[d] + i), 1'b0, $urandom, 4'b0000, 1'b1, 1'b0, g, e);
    endtask

    task automatic test_basic();
        rsp_t g, e;
        op(0, 32'd5, 1'b0, 32'hDEAD_BEEF, 4'b0000, 1'b1, 1'b0, g, e);
        total++;
        if (g.lat !== 3 || g.err !== 1'b0 || g.sc_ok !== 1'b0) begin
            bad++; $display("FAIL basic_write: got %s, want lat=3 sc_ok=0 err=0", fmt(g));
        end
        op(0, 32'd5, 1'b1, 32'h0, 4'b0000, 1'b1, 1'b0, g, e);
        total++;
        if (g.lat !== 3 || g.rdata !== 32'hDEAD_BEEF || g.err !== 1'b0) begin
            bad++; $display("FAIL basic_read: got %s, want lat=3 rdata=deadbeef err=0", fmt(g));
        end
    endtask

    task automatic test_byte_lanes();
        rsp_t g, e;
        op(0, 32'd7, 1'b0, 32'h1122_3344, 4'b0000, 1'b1, 1'b0, g, e);
        op(0, 32'd7, 1'b0, 32'hAABB_CCDD, 4'b1100, 1'b1, 1'b0, g, e);
        op(0, 32'd7, 1'b1, 32'h0, 4'b1111, 1'b1, 1'b0, g, e);
        total++;
        if (g.rdata !== 32'h1122_CCDD) begin
            bad++; $display("FAIL byte_lanes: got %s, want rdata=1122ccdd", fmt(g));
        end
    endtask

    task automatic test_llsc();
        rsp_t g, e;
        op(0, 32'd9, 1'b1, 32'h0, 4'b0000, 1'b0, 1'b0, g, e);
        op(0, 32'd9, 1'b0, 32'd5, 4'b0000, 1'b1, 1'b1, g, e);
        total++;
        if (g.sc_ok !== 1'b1 || g.lat !== 3) begin
            bad++; $display("FAIL sc_after_ll: got %s, want sc_ok=1 lat=3", fmt(g));
        end
        op(0, 32'd9, 1'b1, 32'h0, 4'b0000, 1'b1, 1'b0, g, e);
        total++;
        if (g.rdata !== 32'd5 || g.sc_ok !== 1'b0) begin
            bad++; $display("FAIL sc_word: got %s, want rdata=00000005 sc_ok=0", fmt(g));
        end
        op(0, 32'd9, 1'b1, 32'd6, 4'b0000, 1'b1, 1'b1, g, e);
        total++;
        if (g.sc_ok !== 1'b0) begin
            bad++; $display("FAIL second_sc: got %s, want sc_ok=0", fmt(g));
        end
        op(0, 32'd9, 1'b1, 32'h0, 4'b0000, 1'b1, 1'b0, g, e);
        total++;
        if (g.rdata !== 32'd5) begin
            bad++; $display("FAIL second_sc_word: got %s, want rdata=00000005", fmt(g));
        end
        // plain write to the linked word breaks the link
        op(0, 32'd9, 1'b1, 32'h0, 4'b0000, 1'b0, 1'b0, g, e);
        op(0, 32'd9, 1'b0, 32'd1, 4'b0000, 1'b1, 1'b0, g, e);
        op(0, 32'd9, 1'b0, 32'd2, 4'b0000, 1'b1, 1'b1, g, e);
        total++;
        if (g.sc_ok !== 1'b0) begin
            bad++; $display("FAIL sc_after_plain_write: got %s, want sc_ok=0", fmt(g));
        end
        op(0, 32'd9, 1'b1, 32'h0, 4'b0000, 1'b1, 1'b0, g, e);
        total++;
        if (g.rdata !== 32'd1) begin
            bad++; $display("FAIL plain_write_word: got %s, want rdata=00000001", fmt(g));
        end
        op(0, 32'd10, 1'b0, 32'h0A0A_0A0A, 4'b0000, 1'b1, 1'b0, g, e);
        op(0, 32'd9, 1'b1, 32'h0, 4'b0000, 1'b0, 1'b0, g, e);
        op(0, 32'd10, 1'b0, 32'h5555_5555, 4'b0000, 1'b1, 1'b1, g, e);
        total++;
        if (g.sc_ok !== 1'b0) begin
            bad++; $display("FAIL sc_other_addr: got %s, want sc_ok=0", fmt(g));
        end
        op(0, 32'd10, 1'b1, 32'h0, 4'b0000, 1'b1, 1'b0, g, e);
        total++;
        if (g.rdata !== 32'h0A0A_0A0A) begin
            bad++; $display("FAIL sc_other_word: got %s, want rdata=0a0a0a0a", fmt(g));
        end
    endtask

    task automatic test_addr_err();
        rsp_t g, e;
        op(0, 32'd3, 1'b0, 32'h3333_3333, 4'b0000, 1'b1, 1'b0, g, e);
        op(0, 32'd256, 1'b1, 32'h0, 4'b0000, 1'b1, 1'b0, g, e);
        total++;
        if (g.err !== 1'b1 || g.rdata !== 32'h0 || g.sc_ok !== 1'b0) begin
            bad++; $display("FAIL read_out_of_range: got %s, want rdata=0 sc_ok=0 err=1", fmt(g));
        end
        op(0, 32'd259, 1'b0, 32'hFFFF_0000, 4'b0000, 1'b1, 1'b0, g, e);
        total++;
        if (g.err !== 1'b1) begin
            bad++; $display("FAIL write_out_of_range: got %s, want err=1", fmt(g));
        end
        op(0, 32'd3, 1'b1, 32'h0, 4'b0000, 1'b1, 1'b0, g, e);
        total++;
        if (g.rdata !== 32'h3333_3333 || g.err !== 1'b0) begin
            bad++; $display("FAIL array_unchanged: got %s, want rdata=33333333 err=0", fmt(g));
        end
        op(1, 32'd15, 1'b1, 32'h0, 4'b0000, 1'b1, 1'b0, g, e);
        total++;
        if (g.err !== 1'b1 || g.rdata !== 32'h0 || g.lat !== 1) begin
            bad++; $display("FAIL below_base: got %s, want lat=1 rdata=0 err=1", fmt(g));
        end
    endtask

    task automatic test_reset_midop();
        rsp_t g, e;
        int   seen;
        op(0, 32'd3, 1'b1, 32'h0, 4'b0000, 1'b0, 1'b0, g, e);
        op(1, 32'd20, 1'b1, 32'h0, 4'b0000, 1'b0, 1'b0, g, e);
        @(negedge clk);
        req_valid[0] = 1'b1; addr[0] = 32'd3; rw_[0] = 1'b0; wdata[0] = 32'hFFFF_FFFF;
        byte_en[0] = 4'b0000; load_link_[0] = 1'b1; check_link[0] = 1'b0;
        @(negedge clk);
        req_valid[0] = 1'b0;
        rst_ = 1'b0;
        #1;
        total++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            bad++; $display("FAIL midop_reset_state: rsp_valid=%b ready=%b, want 0 1", rsp_valid[0], req_ready[0]);
        end
        @(negedge clk);
        rst_ = 1'b1;
        lv = '{1'b0, 1'b0};
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid[0]) seen++;
            @(negedge clk);
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL midop_no_rsp: rsp_valid cycles=%0d, want 0", seen);
        end
        op(0, 32'd3, 1'b1, 32'h0, 4'b0000, 1'b1, 1'b0, g, e);
        total++;
        if (g.rdata !== 32'h3333_3333) begin
            bad++; $display("FAIL midop_word: got %s, want rdata=33333333", fmt(g));
        end
        op(0, 32'd3, 1'b0, 32'h7, 4'b0000, 1'b1, 1'b1, g, e);
        total++;
        if (g.sc_ok !== 1'b0) begin
            bad++; $display("FAIL midop_sc0: got %s, want sc_ok=0", fmt(g));
        end
        op(1, 32'd20, 1'b0, 32'h7, 4'b0000, 1'b1, 1'b1, g, e);
        total++;
        if (g.sc_ok !== 1'b0) begin
            bad++; $display("FAIL midop_sc1: got %s, want sc_ok=0", fmt(g));
        end
    endtask

    task automatic test_back_to_back();
        rsp_t g1, g2, e;
        for (int d = 0; d < 2; d++) begin
            op(d, 32'(base[d] + 4), 1'b1, 32'h0, 4'b0000, 1'b1, 1'b0, g1, e);
            op(d, 32'(base[d] + 5), 1'b1, 32'h0, 4'b0000, 1'b1, 1'b0, g2, e);
            total++;
            if ((g2.acc - g1.acc) !== longint'(ws[d] + 2) || g1.lat !== ws[d] + 1 || g2.lat !== ws[d] + 1) begin
                bad++;
                $display("FAIL back_to_back[%0d]: spacing=%0d lat=%0d/%0d, want spacing=%0d lat=%0d",
                         d, g2.acc - g1.acc, g1.lat, g2.lat, ws[d] + 2, ws[d] + 1);
            end
        end
    endtask

    task automatic test_random();
        rsp_t        g, e;
        logic [31:0] a;
        for (int n = 0; n < 400; n++) begin
            int d;
            d = n % 2;
            case ($urandom_range(0, 9))
                0:       a = 32'(base[d]) - 32'(1 + $urandom_range(0, 3));
                1:       a = 32'(base[d] + words[d] + $urandom_range(0, 3));
                default: a = 32'(base[d] + $urandom_range(0, 5));
            endcase
            op(d, a, 1'($urandom), $urandom, 4'($urandom), ($urandom_range(0, 2) != 0),
               ($urandom_range(0, 3) == 0), g, e);
            total++;
            if (g.lat !== e.lat || g.sc_ok !== e.sc_ok || g.err !== e.err ||
                (e.chk_rd && g.rdata !== e.rdata)) begin
                bad++; $display("FAIL random[%0d] dut%0d addr=%h: got %s, want %s", n, d, a, fmt(g), fmt(e));
            end
        end
    endtask

    initial begin
        rst_ = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; addr[d] = 32'h0; rw_[d] = 1'b1; wdata[d] = 32'h0;
            byte_en[d] = 4'b0000; load_link_[d] = 1'b1; check_link[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst_ = 1'b1;
        test_init();
        test_basic();
        test_byte_lanes();
        test_llsc();
        test_addr_err();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
